// File: rtl/x_one_seq_gen.sv
// Serialises a captured pattern MSB-first (bit L-1 down to 0) as stimulus for the X_One sequence detector.
// First bit appears the cycle after start; optional repeats with idle gaps under SEQ_GEN_REPEAT_EN.
module x_one_seq_gen #(
  parameter int PAT_W   = 8,
  parameter int GAP_CYC = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [3:0]       len,
`ifdef SEQ_GEN_REPEAT_EN
  input  logic [3:0]       reps,
`endif
  output logic             out_bit,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;

  localparam logic [3:0] PAT_W4   = 4'(PAT_W);
  localparam logic [3:0] GAP_LAST = 4'(GAP_CYC - 1);

  state_t           state;
  logic [PAT_W-1:0] pat_q;
  logic [3:0]       len_q;
  logic [3:0]       idx;
  logic [3:0]       gap_cnt;
  logic [3:0]       len_eff;
  logic             more_reps;

  // Out-of-range lengths fall back to the full pattern width.
  assign len_eff = (len == 4'd0 || len > PAT_W4) ? PAT_W4 : len;

`ifdef SEQ_GEN_REPEAT_EN
  logic [3:0] rep_q;
  assign more_reps = (rep_q != 4'd0);
`else
  assign more_reps = 1'b0;
`endif

  function automatic logic pick(input logic [PAT_W-1:0] p, input logic [3:0] i);
    logic [PAT_W-1:0] s;
    s = p >> i;
    return s[0];
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      pat_q     <= '0;
      len_q     <= '0;
      idx       <= '0;
      gap_cnt   <= '0;
      out_bit   <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef SEQ_GEN_REPEAT_EN
      rep_q     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            pat_q     <= pattern;
            len_q     <= len_eff;
            idx       <= len_eff - 4'd1;
            out_bit   <= pick(pattern, len_eff - 4'd1);
            out_valid <= 1'b1;
            busy      <= 1'b1;
`ifdef SEQ_GEN_REPEAT_EN
            rep_q     <= reps;
`endif
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (idx == 4'd0) begin
            out_bit   <= 1'b0;
            out_valid <= 1'b0;
            if (more_reps) begin
              gap_cnt <= GAP_LAST;
              state   <= GAP;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end else begin
            idx     <= idx - 4'd1;
            out_bit <= pick(pat_q, idx - 4'd1);
          end
        end
        GAP: begin
          if (gap_cnt == 4'd0) begin
            idx       <= len_q - 4'd1;
            out_bit   <= pick(pat_q, len_q - 4'd1);
            out_valid <= 1'b1;
`ifdef SEQ_GEN_REPEAT_EN
            rep_q     <= rep_q - 4'd1;
`endif
            state     <= SHIFT;
          end else begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end
        DONE: begin
          // Start is ignored here so a held start leaves one IDLE cycle between runs.
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_x_one_seq_gen.sv
// Directed self-checking bench for x_one_seq_gen (PAT_W=8, GAP_CYC=1).
module tb_x_one_seq_gen;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] pattern;
  logic [3:0] len;
`ifdef SEQ_GEN_REPEAT_EN
  logic [3:0] reps;
`endif
  logic       out_bit;
  logic       out_valid;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  x_one_seq_gen #(.PAT_W(8), .GAP_CYC(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .pattern   (pattern),
    .len       (len),
`ifdef SEQ_GEN_REPEAT_EN
    .reps      (reps),
`endif
    .out_bit   (out_bit),
    .out_valid (out_valid),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; pattern = 8'h00; len = 4'd0;
`ifdef SEQ_GEN_REPEAT_EN
    reps = 4'd0;
`endif
    tick(); tick();
    checks++;
    if ({done, busy, out_valid, out_bit} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs got %b exp 0000", {done, busy, out_valid, out_bit});
    end
    reset = 1'b1;
    tick();
    checks++;
    if ({done, busy, out_valid, out_bit} !== 4'b0000) begin
      errors++;
      $display("FAIL idle_after_release got %b exp 0000", {done, busy, out_valid, out_bit});
    end
  endtask

  task automatic test_full_pattern();
    logic [7:0] exp;
    exp = 8'b1011_0010;
    pattern = exp; len = 4'd8; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({out_valid, out_bit} !== {1'b1, exp[7-i]}) begin
        errors++;
        $display("FAIL full_bit%0d got v/b %b exp %b", i, {out_valid, out_bit}, {1'b1, exp[7-i]});
      end
      tick();
    end
    checks++;
    if ({done, busy, out_valid, out_bit} !== 4'b1100) begin
      errors++;
      $display("FAIL full_done got %b exp 1100", {done, busy, out_valid, out_bit});
    end
    tick();
    checks++;
    if ({done, busy} !== 2'b00) begin
      errors++;
      $display("FAIL full_idle got %b exp 00", {done, busy});
    end
  endtask

  task automatic test_len();
    logic [7:0] pats [3];
    logic [3:0] lens [3];
    int         nb   [3];
    logic [7:0] p;
    pats = '{8'hA5, 8'h3C, 8'hC3};
    lens = '{4'd3, 4'd0, 4'd12};
    nb   = '{3, 8, 8};
    for (int k = 0; k < 3; k++) begin
      p = pats[k];
      pattern = p; len = lens[k]; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < nb[k]; i++) begin
        checks++;
        if ({out_valid, out_bit} !== {1'b1, p[nb[k]-1-i]}) begin
          errors++;
          $display("FAIL len%0d_bit%0d got %b exp %b", lens[k], i, {out_valid, out_bit}, {1'b1, p[nb[k]-1-i]});
        end
        tick();
      end
      checks++;
      if ({done, out_valid} !== 2'b10) begin
        errors++;
        $display("FAIL len%0d_done got %b exp 10", lens[k], {done, out_valid});
      end
      tick();
    end
  endtask

  task automatic test_start_ignored();
    logic [7:0] exp;
    int         ndone;
    exp = 8'hF0; ndone = 0;
    pattern = exp; len = 4'd8; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({out_valid, out_bit} !== {1'b1, exp[7-i]}) begin
        errors++;
        $display("FAIL ignore_bit%0d got %b exp %b", i, {out_valid, out_bit}, {1'b1, exp[7-i]});
      end
      if (i == 3) begin
        start = 1'b1; pattern = 8'h0F; len = 4'd2;
      end
      tick();
      start = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      if (done) ndone++;
      tick();
    end
    checks++;
    if (ndone !== 1) begin
      errors++;
      $display("FAIL ignore_done_count got %0d exp 1", ndone);
    end
    checks++;
    if ({busy, out_valid} !== 2'b00) begin
      errors++;
      $display("FAIL ignore_no_relaunch got %b exp 00", {busy, out_valid});
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp;
    exp = 8'h96;
    pattern = exp; len = 4'd4; start = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({out_valid, out_bit} !== {1'b1, exp[3-i]}) begin
        errors++;
        $display("FAIL b2b_bit%0d got %b exp %b", i, {out_valid, out_bit}, {1'b1, exp[3-i]});
      end
      tick();
    end
    checks++;
    if ({done, busy} !== 2'b11) begin
      errors++;
      $display("FAIL b2b_done got %b exp 11", {done, busy});
    end
    tick();
    checks++;
    if ({done, busy, out_valid} !== 3'b000) begin
      errors++;
      $display("FAIL b2b_idle_gap got %b exp 000", {done, busy, out_valid});
    end
    tick();
    start = 1'b0;
    checks++;
    if ({busy, out_valid, out_bit} !== 3'b110) begin
      errors++;
      $display("FAIL b2b_relaunch got %b exp 110", {busy, out_valid, out_bit});
    end
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second_done got %b exp 1", done);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp;
    exp = 8'b1011_0010;
    pattern = exp; len = 4'd8; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    checks++;
    if ({out_valid, out_bit} !== 2'b11) begin
      errors++;
      $display("FAIL mid_bit3 got %b exp 11", {out_valid, out_bit});
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({done, busy, out_valid, out_bit} !== 4'b0000) begin
      errors++;
      $display("FAIL mid_async_clear got %b exp 0000", {done, busy, out_valid, out_bit});
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL mid_no_done cycle %0d got %b exp 0", i, done);
      end
    end
    reset = 1'b1; start = 1'b1; pattern = exp;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({out_valid, out_bit} !== {1'b1, exp[7-i]}) begin
        errors++;
        $display("FAIL mid_restart_bit%0d got %b exp %b", i, {out_valid, out_bit}, {1'b1, exp[7-i]});
      end
      tick();
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL mid_restart_done got %b exp 1", done);
    end
    tick();
  endtask

`ifdef SEQ_GEN_REPEAT_EN
  task automatic test_repeat();
    logic [7:0] exp_v;
    logic [7:0] exp_b;
    exp_v = 8'b1101_1011;
    exp_b = 8'b0100_1001;
    pattern = 8'h01; len = 4'd2; reps = 4'd2; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({out_valid, out_bit} !== {exp_v[7-i], exp_b[7-i]}) begin
        errors++;
        $display("FAIL rep_cyc%0d got %b exp %b", i, {out_valid, out_bit}, {exp_v[7-i], exp_b[7-i]});
      end
      tick();
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL rep_done got %b exp 1", done);
    end
    tick();
    reps = 4'd0;
  endtask
`endif

  initial begin
    test_reset();
    test_full_pattern();
    test_len();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
`ifdef SEQ_GEN_REPEAT_EN
    test_repeat();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
